mem_writer: RTL and testbench
=============================

Name: mem_writer

Overview:
- Loads the two operand memories (mem1, mem2) of the dot-product datapath before mem_reader consumes them.
- Each start_writing accepts one vector of VECTOR_WIDTH element pairs over a valid/ready stream.
- Writes each pair to the same address in both memories, at consecutive addresses from a persistent base pointer.
- Pulses writing_done when the last write is issued.

Parameters:
- DATA_WIDTH, 8, element width in bits.
- VECTOR_WIDTH, 4, elements per vector; legal range 1..7.
- DEPTH, VECTOR_WIDTH*DATA_WIDTH, words per memory.
- ADDR_WIDTH, 5, memory address width; must satisfy 2^ADDR_WIDTH >= DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_writing  in  1  request to load one vector; sampled only in IDLE.
- rewind  in  1  resets base pointer to 0; honoured only in IDLE.
- in_valid  in  1  stream element pair valid.
- in_ready  out  1  stream ready; equals (state==WRITE), combinational from state.
- in_data1  in  DATA_WIDTH  element for mem1.
- in_data2  in  DATA_WIDTH  element for mem2.
- wr_en_mem1, wr_en_mem2  out  1  write strobes, registered, always equal.
- wr_addr_mem1, wr_addr_mem2  out  ADDR_WIDTH  write address, registered, always equal.
- wr_data_mem1, wr_data_mem2  out  DATA_WIDTH  write data, registered.
- writing_done  out  1  one-cycle pulse, asserted while state==DONE.
- element_count  out  3  pairs accepted in current vector.
- base_addr  out  ADDR_WIDTH  current write pointer.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; all outputs 0; pointer=0; element_count=0. Reset mid-WRITE abandons the vector. No further wr_en after reset asserts.
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - rewind=1 sets pointer=0 at the next edge.
  - start_writing=1 moves to WRITE next cycle and clears element_count.
  - If rewind and start_writing are both high, both take effect and the vector is written from address 0.
- WRITE:
  - A handshake is in_valid && in_ready at a rising edge.
  - On a handshake, the next cycle drives wr_en=1, wr_addr=pointer, wr_data=in_data1/in_data2; pointer increments and element_count increments.
  - Write latency is one cycle. With no handshake, wr_en=0 the next cycle.
  - in_valid low stalls indefinitely without timeout.
  - The VECTOR_WIDTH-th handshake moves to DONE, so in_ready is low in the following cycle.
- DONE:
  - writing_done=1 for exactly one cycle, coincident with the last wr_en.
  - Returns to IDLE next cycle. element_count holds VECTOR_WIDTH until the next start.
- start_writing and rewind are ignored outside IDLE, including a start held high through DONE.
- A start held high in IDLE after DONE begins a new vector. Back-to-back vectors therefore cost 2 idle cycles of in_ready.
- Pointer wrap: increments modulo DEPTH, so DEPTH-1 is followed by 0. This is an explicit compare, not reliant on power-of-2 overflow.
- Pointer persists across vectors. With defaults, consecutive vectors land at 0..3, 4..7, 8..11, matching mem_reader's consumption order.
- Data is captured on the handshake edge only; in_data changes with in_valid low have no effect.

Optional Feature:
- MEM_WRITER_OVERFLOW_GUARD_EN defined:
  - Adds output overflow_err (1 bit) and an internal full flag.
  - full sets when the pointer wraps to 0 from a write.
  - start_writing in IDLE while full is rejected: the FSM stays IDLE and overflow_err sets, sticky.
  - rewind or reset clears both full and overflow_err.
- Not defined: no port, no flag; the pointer silently wraps and overwrites from address 0.

Test Plan:
- Reset, start pulse, stream pairs (0x11,0x21),(0x12,0x22),(0x13,0x23),(0x14,0x24) with in_valid constant -> wr_en at addresses 0,1,2,3 with matching data; writing_done pulses once with the addr-3 write; base_addr=4, element_count=4.
- Second and third start pulses, data 0x15..0x1C / 0x25..0x2C -> writes at addresses 4..11; the memory image equals the golden table 0x11..0x1C / 0x21..0x2C at 0..11.
- in_valid deasserted 3 cycles between elements 2 and 3 -> no wr_en during the gap; addresses remain contiguous; done after the 4th handshake only.
- rst_n asserted after 2 elements, then released -> outputs 0 immediately; the next start writes from address 0.
- Eight vectors then a ninth start -> without the macro, the ninth vector writes addresses 0..3. With MEM_WRITER_OVERFLOW_GUARD_EN, the ninth start is rejected, overflow_err=1, no wr_en; rewind then clears it.
- start_writing held high during WRITE and rewind pulsed mid-vector -> both ignored; the pointer continues incrementing.

Source files
------------

// File: rtl/mem_writer.sv
// mem_writer: loads one vector of VECTOR_WIDTH element pairs per start_writing
// into the two operand memories. Each pair goes to the same address in both
// memories. The write pointer persists across vectors and wraps at DEPTH.
// Optional build macro: MEM_WRITER_OVERFLOW_GUARD_EN adds overflow_err and
// rejects a start once the pointer has wrapped.
module mem_writer #(
  parameter int DATA_WIDTH   = 8,
  parameter int VECTOR_WIDTH = 4,
  parameter int DEPTH        = VECTOR_WIDTH * DATA_WIDTH,
  parameter int ADDR_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_writing,
  input  logic                  rewind,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data1,
  input  logic [DATA_WIDTH-1:0] in_data2,
  output logic                  wr_en_mem1,
  output logic                  wr_en_mem2,
  output logic [ADDR_WIDTH-1:0] wr_addr_mem1,
  output logic [ADDR_WIDTH-1:0] wr_addr_mem2,
  output logic [DATA_WIDTH-1:0] wr_data_mem1,
  output logic [DATA_WIDTH-1:0] wr_data_mem2,
  output logic                  writing_done,
`ifdef MEM_WRITER_OVERFLOW_GUARD_EN
  output logic                  overflow_err,
`endif
  output logic [2:0]            element_count,
  output logic [ADDR_WIDTH-1:0] base_addr
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                  state_reg, state_next;
  logic                    wr_en_reg;
  logic [ADDR_WIDTH-1:0]   wr_addr_reg;
  logic [DATA_WIDTH-1:0]   wr_data1_reg, wr_data2_reg;
  logic [ADDR_WIDTH-1:0]   ptr_reg, ptr_inc;
  logic [2:0]              count_reg;
  logic                    handshake, last_elem, start_accept, in_idle, ptr_at_end;

  assign in_idle    = (state_reg == IDLE);
  assign in_ready   = (state_reg == WRITE);
  assign handshake  = in_valid && in_ready;
  assign last_elem  = handshake && (count_reg == 3'(VECTOR_WIDTH - 1));
  // Explicit compare so a non power-of-2 DEPTH still wraps correctly.
  assign ptr_at_end = (ptr_reg == ADDR_WIDTH'(DEPTH - 1));
  assign ptr_inc    = ptr_at_end ? '0 : ptr_reg + 1'b1;

`ifdef MEM_WRITER_OVERFLOW_GUARD_EN
  logic full_reg, overflow_err_reg;

  // A simultaneous rewind clears the full condition, so the start is allowed.
  assign start_accept = start_writing && (!full_reg || rewind);
  assign overflow_err = overflow_err_reg;

  // Track a pointer wrap and latch a sticky error when a start hits a full memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_reg         <= 1'b0;
      overflow_err_reg <= 1'b0;
    end else if (in_idle && rewind) begin
      full_reg         <= 1'b0;
      overflow_err_reg <= 1'b0;
    end else begin
      if (handshake && ptr_at_end)
        full_reg <= 1'b1;
      if (in_idle && start_writing && full_reg)
        overflow_err_reg <= 1'b1;
    end
  end
`else
  assign start_accept = start_writing;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // Next-state logic: start/rewind only matter in IDLE; DONE lasts one cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_accept) state_next = WRITE;
      WRITE:   if (last_elem)    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Write port, pointer and element counter; a handshake produces a write one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data1_reg <= '0;
      wr_data2_reg <= '0;
      ptr_reg      <= '0;
      count_reg    <= '0;
    end else begin
      wr_en_reg <= handshake;
      if (handshake) begin
        wr_addr_reg  <= ptr_reg;
        wr_data1_reg <= in_data1;
        wr_data2_reg <= in_data2;
        ptr_reg      <= ptr_inc;
        count_reg    <= count_reg + 3'd1;
      end else if (in_idle) begin
        if (rewind)
          ptr_reg <= '0;
        if (start_accept)
          count_reg <= '0;
      end
    end
  end

  assign wr_en_mem1    = wr_en_reg;
  assign wr_en_mem2    = wr_en_reg;
  assign wr_addr_mem1  = wr_addr_reg;
  assign wr_addr_mem2  = wr_addr_reg;
  assign wr_data_mem1  = wr_data1_reg;
  assign wr_data_mem2  = wr_data2_reg;
  assign writing_done  = (state_reg == DONE);
  assign element_count = count_reg;
  assign base_addr     = ptr_reg;

endmodule

// File: tb/tb_mem_writer.sv
// tb_mem_writer: directed bench for mem_writer with default parameters
// (8-bit data, 4 pairs per vector, 32-word memories).
// Build with MEM_WRITER_OVERFLOW_GUARD_EN to check the overflow guard path.
module tb_mem_writer;

  localparam int VW = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_writing = 1'b0;
  logic       rewind = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data1 = 8'h00;
  logic [7:0] in_data2 = 8'h00;
  logic       wr_en_mem1, wr_en_mem2;
  logic [4:0] wr_addr_mem1, wr_addr_mem2;
  logic [7:0] wr_data_mem1, wr_data_mem2;
  logic       writing_done;
  logic [2:0] element_count;
  logic [4:0] base_addr;
`ifdef MEM_WRITER_OVERFLOW_GUARD_EN
  logic       overflow_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int stray = 0;

  // Recorded writes: {addr, data1, data2, done, port2_matches}
  logic [22:0] w_word[$];
  logic [7:0]  m1[32];
  logic [7:0]  m2[32];

  mem_writer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_writing(start_writing),
    .rewind       (rewind),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data1     (in_data1),
    .in_data2     (in_data2),
    .wr_en_mem1   (wr_en_mem1),
    .wr_en_mem2   (wr_en_mem2),
    .wr_addr_mem1 (wr_addr_mem1),
    .wr_addr_mem2 (wr_addr_mem2),
    .wr_data_mem1 (wr_data_mem1),
    .wr_data_mem2 (wr_data_mem2),
    .writing_done (writing_done),
`ifdef MEM_WRITER_OVERFLOW_GUARD_EN
    .overflow_err (overflow_err),
`endif
    .element_count(element_count),
    .base_addr    (base_addr)
  );

  always #5 clk = ~clk;

  // Memory model and write recorder, sampled on the falling edge.
  always @(negedge clk) begin
    if (wr_en_mem1 === 1'b1) begin
      w_word.push_back({wr_addr_mem1, wr_data_mem1, wr_data_mem2, writing_done,
                        (wr_en_mem2 === 1'b1 && wr_addr_mem2 === wr_addr_mem1)});
      m1[wr_addr_mem1] = wr_data_mem1;
      m2[wr_addr_mem1] = wr_data_mem2;
    end else if (wr_en_mem2 === 1'b1 || writing_done === 1'b1) begin
      stray++;
    end
  end

  // Expected record for pair i of a vector starting at addr with data bases b1/b2.
  function automatic logic [22:0] exp_word(input logic [4:0] addr, input logic [7:0] b1,
                                           input logic [7:0] b2, input int i);
    return {addr + 5'(i), b1 + 8'(i), b2 + 8'(i), (i == VW - 1), 1'b1};
  endfunction

  function automatic logic [22:0] obs_word(input int i);
    return (i < w_word.size()) ? w_word[i] : 23'h7fffff;
  endfunction

  // Drive one vector: start pulse (optionally with rewind), then VW pairs.
  // gap_after/gap_len insert in_valid-low cycles; hold_start keeps start high
  // until that many handshakes; rewind is held high while rewind_at pairs are done.
  task automatic run_vector(input logic [7:0] b1, input logic [7:0] b2,
                            input int gap_after, input int gap_len,
                            input int hold_start, input int rewind_at, input bit rw);
    int i;
    int guard;
    int gap;
    bit hs;
    w_word.delete();
    start_writing = 1'b1;
    rewind = rw;
    @(negedge clk);
    if (hold_start == 0) start_writing = 1'b0;
    rewind = 1'b0;
    i = 0;
    guard = 0;
    gap = 0;
    while (i < VW && guard < 200) begin
      guard++;
      if (i == gap_after && gap < gap_len) begin
        in_valid = 1'b0;
        in_data1 = 8'hEE;
        in_data2 = 8'hD0 + 8'(gap);
        gap++;
        hs = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data1 = b1 + 8'(i);
        in_data2 = b2 + 8'(i);
        hs = in_ready;
      end
      rewind = (i == rewind_at);
      @(negedge clk);
      if (hs) i++;
      if (hold_start != 0 && i >= hold_start) start_writing = 1'b0;
    end
    in_valid = 1'b0;
    rewind = 1'b0;
    start_writing = 1'b0;
    if (guard >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stream_timeout: got %0d handshakes, want %0d", i, VW);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({in_ready, wr_en_mem1, wr_en_mem2, writing_done} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_strobes: got %b, want 0000", {in_ready, wr_en_mem1, wr_en_mem2, writing_done});
    end
    n_cmp++;
    if ({wr_addr_mem1, wr_addr_mem2, base_addr} !== 15'b0) begin
      n_bad++;
      $display("FAIL reset_addr: got %h, want 0", {wr_addr_mem1, wr_addr_mem2, base_addr});
    end
    n_cmp++;
    if ({wr_data_mem1, wr_data_mem2, element_count} !== 19'b0) begin
      n_bad++;
      $display("FAIL reset_data_count: got %h, want 0", {wr_data_mem1, wr_data_mem2, element_count});
    end
`ifdef MEM_WRITER_OVERFLOW_GUARD_EN
    n_cmp++;
    if (overflow_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_overflow_err: got %b, want 0", overflow_err);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_single();
    run_vector(8'h11, 8'h21, -1, 0, 0, -1, 1'b0);
    n_cmp++;
    if (w_word.size() != VW) begin
      n_bad++;
      $display("FAIL single_nwrites: got %0d, want %0d", w_word.size(), VW);
    end
    for (int i = 0; i < VW; i++) begin
      n_cmp++;
      if (obs_word(i) !== exp_word(5'd0, 8'h11, 8'h21, i)) begin
        n_bad++;
        $display("FAIL single_write%0d: got %h, want %h", i, obs_word(i), exp_word(5'd0, 8'h11, 8'h21, i));
      end
    end
    n_cmp++;
    if ({base_addr, element_count} !== {5'd4, 3'd4}) begin
      n_bad++;
      $display("FAIL single_ptr_count: got base=%0d count=%0d, want base=4 count=4", base_addr, element_count);
    end
    $display("test_single done: %0d writes, base_addr=%0d", w_word.size(), base_addr);
  endtask

  task automatic test_back_to_back();
    run_vector(8'h15, 8'h25, -1, 0, 0, -1, 1'b0);
    for (int i = 0; i < VW; i++) begin
      n_cmp++;
      if (obs_word(i) !== exp_word(5'd4, 8'h15, 8'h25, i)) begin
        n_bad++;
        $display("FAIL b2b_v2_write%0d: got %h, want %h", i, obs_word(i), exp_word(5'd4, 8'h15, 8'h25, i));
      end
    end
    run_vector(8'h19, 8'h29, -1, 0, 0, -1, 1'b0);
    for (int i = 0; i < VW; i++) begin
      n_cmp++;
      if (obs_word(i) !== exp_word(5'd8, 8'h19, 8'h29, i)) begin
        n_bad++;
        $display("FAIL b2b_v3_write%0d: got %h, want %h", i, obs_word(i), exp_word(5'd8, 8'h19, 8'h29, i));
      end
    end
    for (int a = 0; a < 12; a++) begin
      n_cmp++;
      if ({m1[a], m2[a]} !== {8'h11 + 8'(a), 8'h21 + 8'(a)}) begin
        n_bad++;
        $display("FAIL mem_image[%0d]: got %h/%h, want %h/%h", a, m1[a], m2[a], 8'h11 + 8'(a), 8'h21 + 8'(a));
      end
    end
    $display("test_back_to_back done: base_addr=%0d", base_addr);
  endtask

  task automatic test_stall();
    run_vector(8'h1D, 8'h2D, 2, 3, 0, -1, 1'b0);
    n_cmp++;
    if (w_word.size() != VW) begin
      n_bad++;
      $display("FAIL stall_nwrites: got %0d, want %0d", w_word.size(), VW);
    end
    for (int i = 0; i < VW; i++) begin
      n_cmp++;
      if (obs_word(i) !== exp_word(5'd12, 8'h1D, 8'h2D, i)) begin
        n_bad++;
        $display("FAIL stall_write%0d: got %h, want %h", i, obs_word(i), exp_word(5'd12, 8'h1D, 8'h2D, i));
      end
    end
    $display("test_stall done: base_addr=%0d", base_addr);
  endtask

  task automatic test_ignore();
    run_vector(8'h31, 8'h41, -1, 0, 3, 1, 1'b0);
    for (int i = 0; i < VW; i++) begin
      n_cmp++;
      if (obs_word(i) !== exp_word(5'd16, 8'h31, 8'h41, i)) begin
        n_bad++;
        $display("FAIL ignore_write%0d: got %h, want %h", i, obs_word(i), exp_word(5'd16, 8'h31, 8'h41, i));
      end
    end
    n_cmp++;
    if (base_addr !== 5'd20) begin
      n_bad++;
      $display("FAIL ignore_ptr: got %0d, want 20", base_addr);
    end
    $display("test_ignore done: base_addr=%0d", base_addr);
  endtask

  task automatic test_reset_mid();
    w_word.delete();
    start_writing = 1'b1;
    @(negedge clk);
    start_writing = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data1 = 8'h51 + 8'(i);
      in_data2 = 8'h61 + 8'(i);
      @(negedge clk);
    end
    n_cmp++;
    if ({element_count, base_addr, wr_en_mem1, wr_addr_mem1} !== {3'd2, 5'd22, 1'b1, 5'd21}) begin
      n_bad++;
      $display("FAIL midvec_state: got count=%0d base=%0d wr_en=%b addr=%0d, want 2 22 1 21",
               element_count, base_addr, wr_en_mem1, wr_addr_mem1);
    end
    in_data1 = 8'h53;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, wr_en_mem1, writing_done, wr_addr_mem1, base_addr, element_count} !== 16'b0) begin
      n_bad++;
      $display("FAIL async_reset: got ready=%b wr_en=%b done=%b addr=%0d base=%0d count=%0d, want all 0",
               in_ready, wr_en_mem1, writing_done, wr_addr_mem1, base_addr, element_count);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (w_word.size() != 2) begin
      n_bad++;
      $display("FAIL reset_no_more_writes: got %0d writes, want 2", w_word.size());
    end
    run_vector(8'h71, 8'h81, -1, 0, 0, -1, 1'b0);
    for (int i = 0; i < VW; i++) begin
      n_cmp++;
      if (obs_word(i) !== exp_word(5'd0, 8'h71, 8'h81, i)) begin
        n_bad++;
        $display("FAIL after_reset_write%0d: got %h, want %h", i, obs_word(i), exp_word(5'd0, 8'h71, 8'h81, i));
      end
    end
    $display("test_reset_mid done: base_addr=%0d", base_addr);
  endtask

  task automatic test_rewind_start();
    run_vector(8'h91, 8'hA1, -1, 0, 0, -1, 1'b1);
    for (int i = 0; i < VW; i++) begin
      n_cmp++;
      if (obs_word(i) !== exp_word(5'd0, 8'h91, 8'hA1, i)) begin
        n_bad++;
        $display("FAIL rewind_start_write%0d: got %h, want %h", i, obs_word(i), exp_word(5'd0, 8'h91, 8'hA1, i));
      end
    end
    $display("test_rewind_start done: base_addr=%0d", base_addr);
  endtask

  task automatic test_wrap();
    bit ready_seen;
    rewind = 1'b1;
    @(negedge clk);
    rewind = 1'b0;
    n_cmp++;
    if (base_addr !== 5'd0) begin
      n_bad++;
      $display("FAIL rewind_ptr: got %0d, want 0", base_addr);
    end
    for (int k = 0; k < 8; k++) begin
      run_vector(8'(4 * k), 8'(128 + 4 * k), -1, 0, 0, -1, 1'b0);
      for (int i = 0; i < VW; i++) begin
        n_cmp++;
        if (obs_word(i) !== exp_word(5'(4 * k), 8'(4 * k), 8'(128 + 4 * k), i)) begin
          n_bad++;
          $display("FAIL fill_v%0d_write%0d: got %h, want %h", k, i, obs_word(i),
                   exp_word(5'(4 * k), 8'(4 * k), 8'(128 + 4 * k), i));
        end
      end
    end
    n_cmp++;
    if (base_addr !== 5'd0) begin
      n_bad++;
      $display("FAIL wrap_ptr: got %0d, want 0", base_addr);
    end
`ifdef MEM_WRITER_OVERFLOW_GUARD_EN
    w_word.delete();
    ready_seen = 1'b0;
    start_writing = 1'b1;
    @(negedge clk);
    start_writing = 1'b0;
    for (int c = 0; c < 4; c++) begin
      ready_seen |= in_ready;
      @(negedge clk);
    end
    n_cmp++;
    if ({ready_seen, overflow_err} !== 2'b01 || w_word.size() != 0) begin
      n_bad++;
      $display("FAIL overflow_reject: got ready_seen=%b err=%b writes=%0d, want 0 1 0",
               ready_seen, overflow_err, w_word.size());
    end
    rewind = 1'b1;
    @(negedge clk);
    rewind = 1'b0;
    n_cmp++;
    if ({overflow_err, base_addr} !== 6'b0) begin
      n_bad++;
      $display("FAIL overflow_clear: got err=%b base=%0d, want 0 0", overflow_err, base_addr);
    end
`else
    ready_seen = 1'b0;
`endif
    run_vector(8'hC1, 8'hD1, -1, 0, 0, -1, 1'b0);
    for (int i = 0; i < VW; i++) begin
      n_cmp++;
      if (obs_word(i) !== exp_word(5'd0, 8'hC1, 8'hD1, i)) begin
        n_bad++;
        $display("FAIL ninth_write%0d: got %h, want %h", i, obs_word(i), exp_word(5'd0, 8'hC1, 8'hD1, i));
      end
    end
    n_cmp++;
    if ({m1[0], m2[0], ready_seen} !== {8'hC1, 8'hD1, 1'b0}) begin
      n_bad++;
      $display("FAIL overwrite_addr0: got %h/%h, want c1/d1", m1[0], m2[0]);
    end
    $display("test_wrap done: base_addr=%0d", base_addr);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_ignore();
    test_reset_mid();
    test_rewind_start();
    test_wrap();
    n_cmp++;
    if (stray != 0) begin
      n_bad++;
      $display("FAIL stray_strobes: got %0d, want 0", stray);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
